pipeline_hazard_ctrl: RTL and testbench

//  Issue controller for the decode pipeline registers: decides each cycle whether the decoded instruction may enter stage three.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_scoreboard.sv | 80 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller.
// Optional bypass support is selected with the PIPE_FWD_EN macro.
package pipe_ctrl_pkg;

    localparam int unsigned DEF_NREG = 8;
    localparam int unsigned DEF_AW   = $clog2(DEF_NREG);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bits needed to hold a down-counter that starts at max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register countdown scoreboard with RAW/WAW/SP hazard detection.
// PIPE_FWD_EN: sources one cycle from write-back are bypassed instead of stalled.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter  int unsigned NREG       = DEF_NREG,
    parameter  int unsigned WB_LATENCY = 3,
    localparam int unsigned AW         = $clog2(NREG),
    localparam int unsigned CW         = cnt_width(WB_LATENCY)
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic          issue,
    input  logic [AW-1:0] srcA,
    input  logic          srcA_use,
    input  logic [AW-1:0] srcB,
    input  logic          srcB_use,
    input  logic [AW-1:0] writeAd,
    input  logic          write,
    input  logic          SPR_use,
    output logic          hazard,
    output logic          fwdA_cand,
    output logic          fwdB_cand
);

    // The issue cycle is the first of WB_LATENCY, so the counter holds the
    // number of further cycles a consumer must wait.
    localparam logic [CW-1:0] LOAD = CW'(WB_LATENCY - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] sp_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sp_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (issue && write && (writeAd == AW'(r))) begin
                    cnt[r] <= LOAD;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - ONE;
                end
            end
            if (issue && SPR_use) begin
                sp_cnt <= LOAD;
            end else if (sp_cnt != '0) begin
                sp_cnt <= sp_cnt - ONE;
            end
        end
    end

    logic a_busy;
    logic b_busy;
    logic waw_busy;
    logic sp_busy;

    always_comb begin
        a_busy    = 1'b0;
        b_busy    = 1'b0;
        fwdA_cand = 1'b0;
        fwdB_cand = 1'b0;
`ifdef PIPE_FWD_EN
        a_busy    = srcA_use && (cnt[srcA] > ONE);
        b_busy    = srcB_use && (cnt[srcB] > ONE);
        fwdA_cand = srcA_use && (cnt[srcA] == ONE);
        fwdB_cand = srcB_use && (cnt[srcB] == ONE);
`else
        a_busy    = srcA_use && (cnt[srcA] != '0);
        b_busy    = srcB_use && (cnt[srcB] != '0);
`endif
        waw_busy  = write && (cnt[writeAd] != '0);
        sp_busy   = SPR_use && (sp_cnt != '0);
        hazard    = a_busy || b_busy || waw_busy || sp_busy;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage issue controller: stall/bubble/flush enables for the pipeline registers.
// Build with PIPE_FWD_EN defined to enable source bypass from the last write-back cycle.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter  int unsigned NREG         = DEF_NREG,
    parameter  int unsigned WB_LATENCY   = 3,
    parameter  int unsigned FLUSH_CYCLES = 2,
    localparam int unsigned AW           = $clog2(NREG)
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic          issue_valid_IN,
    input  logic [AW-1:0] srcA_IN,
    input  logic          srcA_use_IN,
    input  logic [AW-1:0] srcB_IN,
    input  logic          srcB_use_IN,
    input  logic [AW-1:0] writeAd_IN,
    input  logic          write_IN,
    input  logic          SPR_use_IN,
    input  logic          PC_load_IN,
    output logic          issue_OUT,
    output logic          stall_OUT,
    output logic          bubble_OUT,
    output logic          flush_OUT,
    output logic          fwdA_OUT,
    output logic          fwdB_OUT
);

    localparam int unsigned   FW         = cnt_width(FLUSH_CYCLES);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_n;

    logic hazard;
    logic fwdA_cand;
    logic fwdB_cand;

    pipe_scoreboard #(
        .NREG       (NREG),
        .WB_LATENCY (WB_LATENCY)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .issue     (issue_OUT),
        .srcA      (srcA_IN),
        .srcA_use  (srcA_use_IN),
        .srcB      (srcB_IN),
        .srcB_use  (srcB_use_IN),
        .writeAd   (writeAd_IN),
        .write     (write_IN),
        .SPR_use   (SPR_use_IN),
        .hazard    (hazard),
        .fwdA_cand (fwdA_cand),
        .fwdB_cand (fwdB_cand)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        if (PC_load_IN) begin
            state_n = FLUSH;
            fcnt_n  = FLUSH_LOAD;
        end else begin
            unique case (state)
                RUN: begin
                    if (issue_valid_IN && hazard) state_n = STALL;
                end
                STALL: begin
                    if (!hazard || !issue_valid_IN) state_n = RUN;
                end
                FLUSH: begin
                    if (fcnt == '0) state_n = RUN;
                    else            fcnt_n  = fcnt - FW'(1);
                end
                default: state_n = RUN;
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of state.
    always_comb begin
        flush_OUT  = !RST && (PC_load_IN || (state == FLUSH));
        issue_OUT  = !RST && issue_valid_IN && !hazard && !flush_OUT;
        stall_OUT  = !RST && issue_valid_IN &&  hazard && !flush_OUT;
        bubble_OUT = !RST && !issue_OUT;
        fwdA_OUT   = issue_OUT && fwdA_cand;
        fwdB_OUT   = issue_OUT && fwdB_cand;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table plus random
// stimulus against a timestamp-based reference model (honours PIPE_FWD_EN).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned NREG = 8;
    localparam int unsigned L    = 3;
    localparam int unsigned FC   = 2;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       issue_valid_IN = 1'b0;
    logic [2:0] srcA_IN = '0;
    logic       srcA_use_IN = 1'b0;
    logic [2:0] srcB_IN = '0;
    logic       srcB_use_IN = 1'b0;
    logic [2:0] writeAd_IN = '0;
    logic       write_IN = 1'b0;
    logic       SPR_use_IN = 1'b0;
    logic       PC_load_IN = 1'b0;
    logic       issue_OUT, stall_OUT, bubble_OUT, flush_OUT, fwdA_OUT, fwdB_OUT;

    pipeline_hazard_ctrl #(
        .NREG         (NREG),
        .WB_LATENCY   (L),
        .FLUSH_CYCLES (FC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .issue_valid_IN (issue_valid_IN),
        .srcA_IN        (srcA_IN),
        .srcA_use_IN    (srcA_use_IN),
        .srcB_IN        (srcB_IN),
        .srcB_use_IN    (srcB_use_IN),
        .writeAd_IN     (writeAd_IN),
        .write_IN       (write_IN),
        .SPR_use_IN     (SPR_use_IN),
        .PC_load_IN     (PC_load_IN),
        .issue_OUT      (issue_OUT),
        .stall_OUT      (stall_OUT),
        .bubble_OUT     (bubble_OUT),
        .flush_OUT      (flush_OUT),
        .fwdA_OUT       (fwdA_OUT),
        .fwdB_OUT       (fwdB_OUT)
    );

    always #5 CLK = ~CLK;

    // e = {issue, stall, bubble, flush, fwdA, fwdB}
    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] a;
        logic       ua;
        logic [2:0] b;
        logic       ub;
        logic [2:0] wa;
        logic       we;
        logic       spr;
        logic       pc;
        logic [5:0] e;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: cycle at which each register / SP becomes readable,
    // and the last cycle of the post-PC-load squash window.
    int cyc = 0;
    int ready_at[NREG];
    int sp_ready = 0;
    int flush_end = -1;
    logic [5:0] exp_o;

    function automatic vec_t mk(input logic rst, input logic v, input logic [2:0] a, input logic ua,
                                input logic [2:0] b, input logic ub, input logic [2:0] wa, input logic we,
                                input logic spr, input logic pc, input logic [5:0] e);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.ua = ua; t.b = b; t.ub = ub;
        t.wa = wa; t.we = we; t.spr = spr; t.pc = pc; t.e = e;
        return t;
    endfunction

    function automatic bit src_busy(input logic [2:0] r);
        return FWD ? (cyc < ready_at[r] - 1) : (cyc < ready_at[r]);
    endfunction

    function automatic logic [5:0] model_eval(input vec_t t);
        bit haz, fl, iss;
        if (t.rst) return 6'b000000;
        haz = (t.ua && src_busy(t.a)) || (t.ub && src_busy(t.b)) ||
              (t.we && (cyc < ready_at[t.wa])) || (t.spr && (cyc < sp_ready));
        fl  = t.pc || (cyc <= flush_end);
        iss = t.v && !haz && !fl;
        return {iss, t.v && haz && !fl, !iss, fl,
                FWD && iss && t.ua && (cyc == ready_at[t.a] - 1),
                FWD && iss && t.ub && (cyc == ready_at[t.b] - 1)};
    endfunction

    task automatic model_commit(input vec_t t, input logic [5:0] e);
        if (t.rst) begin
            for (int i = 0; i < NREG; i++) ready_at[i] = 0;
            sp_ready  = 0;
            flush_end = -1;
        end else begin
            if (e[5] && t.we)  ready_at[t.wa] = cyc + L;
            if (e[5] && t.spr) sp_ready = cyc + L;
            if (t.pc)          flush_end = cyc + FC;
        end
        cyc++;
    endtask

    task automatic drive(input vec_t t);
        @(negedge CLK);
        RST = t.rst; issue_valid_IN = t.v;
        srcA_IN = t.a; srcA_use_IN = t.ua; srcB_IN = t.b; srcB_use_IN = t.ub;
        writeAd_IN = t.wa; write_IN = t.we; SPR_use_IN = t.spr; PC_load_IN = t.pc;
        #2;
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %b expected %b", name, idx, $time, act, expv);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [5:0] e);
        chk({tag, ".issue"},  idx, issue_OUT,  e[5]);
        chk({tag, ".stall"},  idx, stall_OUT,  e[4]);
        chk({tag, ".bubble"}, idx, bubble_OUT, e[3]);
        chk({tag, ".flush"},  idx, flush_OUT,  e[2]);
        chk({tag, ".fwdA"},   idx, fwdA_OUT,   e[1]);
        chk({tag, ".fwdB"},   idx, fwdB_OUT,   e[0]);
    endtask

    initial begin
        vec_t t;
        for (int i = 0; i < NREG; i++) ready_at[i] = 0;

        // Reset held with a valid instruction present: everything low.
        tbl.push_back(mk(1,1, 3'd2,1, 3'd0,0, 3'd1,1, 0,0, 6'b000000));
        tbl.push_back(mk(1,1, 3'd2,1, 3'd0,0, 3'd1,1, 0,0, 6'b000000));
        // Independent ops r1<-r2, r3<-r4 issue back to back.
        tbl.push_back(mk(0,1, 3'd2,1, 3'd0,0, 3'd1,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd4,1, 3'd0,0, 3'd3,1, 0,0, 6'b100000));
`ifndef PIPE_FWD_EN
        // RAW on r5: two stall cycles, issue on the third.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd5,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd6,1, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd6,1, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd6,1, 0,0, 6'b100000));
        // PC load while stalled on r6: squash window, then issue.
        tbl.push_back(mk(0,1, 3'd6,1, 3'd0,0, 3'd0,0, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd6,1, 3'd0,0, 3'd0,0, 0,1, 6'b001100));
        tbl.push_back(mk(0,1, 3'd6,1, 3'd0,0, 3'd0,0, 0,0, 6'b001100));
        tbl.push_back(mk(0,1, 3'd6,1, 3'd0,0, 3'd0,0, 0,0, 6'b001100));
        tbl.push_back(mk(0,1, 3'd6,1, 3'd0,0, 3'd7,1, 0,0, 6'b100000));
        // r7 counter expires inside a flush window.
        tbl.push_back(mk(0,0, 3'd0,0, 3'd0,0, 3'd0,0, 0,1, 6'b001100));
        tbl.push_back(mk(0,1, 3'd7,1, 3'd0,0, 3'd0,0, 0,0, 6'b001100));
        tbl.push_back(mk(0,1, 3'd7,1, 3'd0,0, 3'd0,0, 0,0, 6'b001100));
        tbl.push_back(mk(0,1, 3'd7,1, 3'd0,0, 3'd0,0, 0,0, 6'b100000));
        // Back-to-back SP users.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b100000));
        // Reset mid-stall clears the scoreboard.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd5,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b011000));
        tbl.push_back(mk(1,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b000000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b100000));
        // r0 is tracked; read through srcB.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,1, 3'd0,0, 0,0, 6'b011000));
        tbl.push_back(mk(0,0, 3'd0,0, 3'd0,0, 3'd0,0, 0,0, 6'b001000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,1, 3'd0,0, 0,0, 6'b100000));
        // WAW on r1.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b011000));
        tbl.push_back(mk(0,0, 3'd0,0, 3'd0,0, 3'd0,0, 0,0, 6'b001000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b100000));
`else
        // Bypass: one stall cycle, then issue with forwarding.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd5,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b100010));
        tbl.push_back(mk(0,1, 3'd5,1, 3'd0,0, 3'd0,0, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd3,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd3,1, 3'd0,0, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd3,1, 3'd0,0, 0,0, 6'b100001));
        // WAW and SP are never bypassed.
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd1,1, 0,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b100000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b011000));
        tbl.push_back(mk(0,1, 3'd0,0, 3'd0,0, 3'd0,0, 1,0, 6'b100000));
`endif

        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_o = model_eval(tbl[i]);
            check_all("vec", i, tbl[i].e);
            @(posedge CLK);
            model_commit(tbl[i], exp_o);
        end

        for (int i = 0; i < 800; i++) begin
            t = mk($urandom_range(63) == 0, $urandom_range(3) != 0,
                   3'($urandom_range(3)), $urandom_range(1) == 1,
                   3'($urandom_range(3)), $urandom_range(1) == 1,
                   3'($urandom_range(7)), $urandom_range(2) == 0,
                   $urandom_range(5) == 0, $urandom_range(15) == 0, 6'b000000);
            drive(t);
            exp_o = model_eval(t);
            check_all("rand", i, exp_o);
            @(posedge CLK);
            model_commit(t, exp_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
